// File: rtl/seven_seg_decoder_if.sv
// Bundle between a seven-segment pattern source and the decoder: raw pattern
// and error-clear in, decoded digit/status/error count out.
interface seven_seg_if;
    logic [6:0] seg_in;
    logic       err_clr;
    logic [3:0] value;
    logic       valid;
    logic       blank;
    logic       invalid;
    logic       upd;
    logic [7:0] err_count;

    modport master (
        output seg_in, err_clr,
        input  value, valid, blank, invalid, upd, err_count
    );

    modport slave (
        input  seg_in, err_clr,
        output value, valid, blank, invalid, upd, err_count
    );
endinterface

// File: rtl/seven_seg_decoder.sv
// Decodes an asynchronous active-low seven-segment pattern into a hex digit
// once it has been stable for STABLE_CYCLES consecutive matching samples.
module seven_seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk_ref,
    input  logic        reset_n,
    seven_seg_if.slave  bus
);

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [7:0] LAST_CNT  = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Returns {legal, digit}; active-low segments, bit0 = a ... bit6 = g.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = {1'b1, 4'h0};
            7'h79:   decode = {1'b1, 4'h1};
            7'h24:   decode = {1'b1, 4'h2};
            7'h30:   decode = {1'b1, 4'h3};
            7'h19:   decode = {1'b1, 4'h4};
            7'h12:   decode = {1'b1, 4'h5};
            7'h02:   decode = {1'b1, 4'h6};
            7'h78:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h18:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h03:   decode = {1'b1, 4'hB};
            7'h46:   decode = {1'b1, 4'hC};
            7'h21:   decode = {1'b1, 4'hD};
            7'h06:   decode = {1'b1, 4'hE};
            7'h0E:   decode = {1'b1, 4'hF};
            default: decode = {1'b0, 4'h0};
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        sat_inc = (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic [6:0] r_s1, r_s2, r_prev;
    logic [7:0] r_cnt;
    logic [0:0] r_state;
    logic [3:0] r_value;
    logic       r_valid, r_blank, r_invalid, r_upd;
    logic [7:0] r_err;

    logic       w_match, w_accept;
    logic [4:0] w_dec;
    logic [3:0] w_nxt_value;
    logic       w_nxt_valid, w_nxt_blank, w_nxt_invalid;

    assign w_match  = (r_s2 == r_prev);
    assign w_accept = (r_state == ST_SETTLE) && w_match && (r_cnt == LAST_CNT);
    assign w_dec    = decode(r_s2);

    // Blank and illegal patterns leave the last digit in place.
    always_comb begin
        w_nxt_value   = r_value;
        w_nxt_valid   = 1'b0;
        w_nxt_blank   = 1'b0;
        w_nxt_invalid = 1'b0;
        if (w_dec[4]) begin
            w_nxt_value = w_dec[3:0];
            w_nxt_valid = 1'b1;
        end else if (r_s2 == SEG_BLANK) begin
            w_nxt_blank = 1'b1;
        end else begin
            w_nxt_invalid = 1'b1;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            r_s1      <= SEG_BLANK;
            r_s2      <= SEG_BLANK;
            r_prev    <= SEG_BLANK;
            r_cnt     <= 8'd0;
            r_state   <= ST_SETTLE;
            r_value   <= 4'h0;
            r_valid   <= 1'b0;
            r_blank   <= 1'b1;
            r_invalid <= 1'b0;
            r_upd     <= 1'b0;
            r_err     <= 8'd0;
        end else begin
            r_s1   <= bus.seg_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_upd  <= 1'b0;

            if (!w_match) begin
                r_cnt   <= 8'd0;
                r_state <= ST_SETTLE;
            end else if (w_accept) begin
                r_state   <= ST_LOCKED;
                r_value   <= w_nxt_value;
                r_valid   <= w_nxt_valid;
                r_blank   <= w_nxt_blank;
                r_invalid <= w_nxt_invalid;
                r_upd     <= {w_nxt_value, w_nxt_valid, w_nxt_blank, w_nxt_invalid}
                             != {r_value, r_valid, r_blank, r_invalid};
            end else if (r_state == ST_SETTLE && r_cnt < LAST_CNT) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (bus.err_clr)
                r_err <= 8'd0;
            else if (w_accept && w_nxt_invalid)
                r_err <= sat_inc(r_err);
        end
    end

    assign bus.value     = r_value;
    assign bus.valid     = r_valid;
    assign bus.blank     = r_blank;
    assign bus.invalid   = r_invalid;
    assign bus.upd       = r_upd;
    assign bus.err_count = r_err;

endmodule
